spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_master_if.sv | 28 ++
 rtl/spi_clk_div.sv | 31 +++
 rtl/spi_master.sv | 116 +++++++++++
 tb/tb_spi_master.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, SPI mode, default divider.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   // Mode 0: clock idles low, data sampled on the rising sck edge.
   localparam int   SPI_MODE        = 0;
   localparam logic SCK_IDLE        = (SPI_MODE >= 2) ? 1'b1 : 1'b0;

   localparam int   DEFAULT_CLK_DIV = 4;
   localparam int   SPI_BITS        = 8;

endpackage

// File: rtl/spi_master_if.sv
// Bundles the SPI master's request/response handshake and serial pins.
// Latency: n/a (wiring only).
// Backpressure: none; the requester watches busy/done.
//   master modport : DUT side (drives ss, sck, mosi, busy, done, dout)
//   slave modport  : requester / peer side (drives start, din, miso)
interface spi_master_if;

   logic       start;
   logic [7:0] din;
   logic       busy;
   logic       done;
   logic [7:0] dout;
   logic       ss;
   logic       sck;
   logic       mosi;
   logic       miso;

   modport master (
      input  start, din, miso,
      output busy, done, dout, ss, sck, mosi
   );

   modport slave (
      output start, din, miso,
      input  busy, done, dout, ss, sck, mosi
   );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period divider for sck: counts 0..CLK_DIV-1 and flags the terminal count.
// Latency: tick asserts CLK_DIV cycles after the counter leaves clear.
// Backpressure: none; en pauses the count, clr forces it to zero.
//   clk, rst : clock, async active-low reset
//   en, clr  : count enable, synchronous clear (clear wins)
//   tick     : high in the cycle the counter sits at its terminal count
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   logic [7:0] cnt;

   assign tick = en && !clr && (cnt == 8'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 8'd0;
      end else if (clr) begin
         cnt <= 8'd0;
      end else if (en) begin
         cnt <= tick ? 8'd0 : cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte out on mosi (MSB first) while one byte is read from miso.
// Latency: start accepted at edge N -> done and ss=1 after edge N+18*CLK_DIV.
// Backpressure: start is only looked at in IDLE; requests while busy are dropped.
//   clk, rst : clock, async active-low reset
//   bus      : spi_master_if.master (start/din in, busy/done/dout out, ss/sck/mosi/miso pins)
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic          clk,
   input  logic          rst,
   spi_master_if.master  bus
);

   spi_state_t state;
   logic [6:0] tx_sh;      // bits still to be presented, next one at [6]
   logic [7:0] rx_sh;
   logic [2:0] bit_cnt;    // falling sck edges seen so far
   logic       last;       // eighth fall done; one more low half-period before HOLD
   logic       tick;

   logic       ss_r;
   logic       sck_r;
   logic       mosi_r;
   logic       busy_r;
   logic       done_r;
   logic [7:0] dout_r;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .rst  (rst),
      .en   (state != IDLE),
      .clr  (state == IDLE),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         tx_sh   <= 7'd0;
         rx_sh   <= 8'd0;
         bit_cnt <= 3'd0;
         last    <= 1'b0;
         ss_r    <= 1'b1;
         sck_r   <= SCK_IDLE;
         mosi_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         dout_r  <= 8'h00;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  tx_sh   <= bus.din[6:0];
                  mosi_r  <= bus.din[7];
                  rx_sh   <= 8'd0;
                  bit_cnt <= 3'd0;
                  last    <= 1'b0;
                  ss_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               // First rising edge: the slave and this master both sample here.
               if (tick) begin
                  sck_r <= 1'b1;
                  rx_sh <= {rx_sh[6:0], bus.miso};
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (last) begin
                     mosi_r <= 1'b0;
                     state  <= HOLD;
                  end else if (sck_r) begin
                     // Falling edge: move the next bit onto mosi (zeros once drained).
                     sck_r  <= 1'b0;
                     mosi_r <= tx_sh[6];
                     tx_sh  <= {tx_sh[5:0], 1'b0};
                     if (bit_cnt == 3'd7) begin
                        last <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end else begin
                     sck_r <= 1'b1;
                     rx_sh <= {rx_sh[6:0], bus.miso};
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  ss_r   <= 1'b1;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  dout_r <= rx_sh;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ss   = ss_r;
   assign bus.sck  = sck_r;
   assign bus.mosi = mosi_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.dout = dout_r;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table of transfers against a byte-level model, plus
// busy-start, mid-transfer reset and back-to-back corner sequences.
module tb_spi_master;
   import spi_pkg::*;

   localparam int D4  = 4;
   localparam int D2  = 2;
   localparam int LIM = 2000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_if b4 ();
   spi_master_if b2 ();

   spi_master #(.CLK_DIV(D4)) u4 (.clk(clk), .rst(rst), .bus(b4.master));
   spi_master #(.CLK_DIV(D2)) u2 (.clk(clk), .rst(rst), .bus(b2.master));

   // miso source for u4: 0 = loopback, 1 = tied high, 2 = slave model
   logic [1:0] miso_mode = 2'd0;
   logic [7:0] sl_tx = 8'h00;
   logic [7:0] sl_sh = 8'h00;
   logic [7:0] sl_rx = 8'h00;

   assign b4.miso = (miso_mode == 2'd0) ? b4.mosi :
                    (miso_mode == 2'd1) ? 1'b1 : sl_sh[7];
   assign b2.miso = b2.mosi;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor + slave model on u4, sampled on the falling clk edge.
   logic       p_ss  = 1'b1;
   logic       p_sck = 1'b0;
   int         run = 0, rises = 0, phase_err = 0, done_cnt = 0, sck_ss_err = 0;
   logic [7:0] mosi_cap = 8'h00;

   always @(negedge clk) begin
      p_ss  <= b4.ss;
      p_sck <= b4.sck;
      if (b4.done === 1'b1) done_cnt <= done_cnt + 1;
      if (b4.ss === 1'b1 && b4.sck === 1'b1) sck_ss_err <= sck_ss_err + 1;
      if (p_ss && !b4.ss) begin
         rises     <= 0;
         mosi_cap  <= 8'h00;
         phase_err <= 0;
         sl_rx     <= 8'h00;
         sl_sh     <= sl_tx;
         run       <= 1;
      end else if (b4.sck != p_sck) begin
         run <= 1;
         if (p_sck && run != D4) phase_err <= phase_err + 1;
         if (!p_sck && rises != 0 && run != D4) phase_err <= phase_err + 1;
         if (!p_sck) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[6:0], b4.mosi};
            sl_rx    <= {sl_rx[6:0], b4.mosi};
         end else if (!b4.ss) begin
            sl_sh <= {sl_sh[6:0], 1'b0};
         end
      end else begin
         run <= run + 1;
      end
   end

   // Byte-level expectation: what the master should end up holding.
   function automatic logic [7:0] model_rx(input logic [1:0] mode, input logic [7:0] d,
                                           input logic [7:0] sb);
      case (mode)
         2'd0:    return d;
         2'd1:    return 8'hFF;
         default: return sb;
      endcase
   endfunction

   typedef struct {
      logic [7:0] din;
      logic [1:0] mode;
      logic [7:0] miso_byte;
      logic [7:0] exp_dout;
      int         exp_lat;
   } vec_t;

   vec_t vecs[8];

   // Caller sits just after an active edge; returns cycles until done is seen.
   task automatic wait_done(input int lim, output int cyc);
      cyc = 0;
      while (b4.done !== 1'b1 && cyc < lim) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_xfer(input vec_t v);
      int cyc;
      logic [7:0] d;
      d         = v.din;
      miso_mode = v.mode;
      sl_tx     = v.miso_byte;
      @(negedge clk);
      b4.start = 1'b1;
      b4.din   = d;
      @(posedge clk); #1;
      b4.start = 1'b0;
      b4.din   = ~d;          // must not disturb the accepted byte
      chk("accept_ss", b4.ss, 1'b0);
      chk("accept_busy", b4.busy, 1'b1);
      chk("accept_mosi", b4.mosi, d[7]);
      wait_done(LIM, cyc);
      chk("latency", cyc, v.exp_lat);
      chk("dout", b4.dout, v.exp_dout);
      chk("done_ss", b4.ss, 1'b1);
      chk("done_busy", b4.busy, 1'b0);
      chk("done_mosi", b4.mosi, 1'b0);
      chk("sck_rises", rises, 8);
      chk("mosi_bits", mosi_cap, d);
      chk("sck_phase", phase_err, 0);
      if (v.mode == 2'd2) chk("slave_rx", sl_rx, d);
      @(posedge clk); #1;
      chk("done_pulse", b4.done, 1'b0);
      chk("dout_hold", b4.dout, v.exp_dout);
   endtask

   initial begin
      int cyc, d0, n_done, last_c, ss_run;
      b4.start = 1'b0; b4.din = 8'h00;
      b2.start = 1'b0; b2.din = 8'h00;

      vecs[0] = '{8'hA5, 2'd0, 8'h00, 8'h00, 0};
      vecs[1] = '{8'h00, 2'd1, 8'h00, 8'h00, 0};
      vecs[2] = '{8'h3C, 2'd2, 8'hFF, 8'h00, 0};
      vecs[3] = '{8'hC3, 2'd2, 8'h5A, 8'h00, 0};
      for (int i = 4; i < 8; i++) begin
         vecs[i].din       = 8'($urandom_range(0, 255));
         vecs[i].mode      = 2'($urandom_range(0, 2));
         vecs[i].miso_byte = 8'($urandom_range(0, 255));
      end
      for (int i = 0; i < 8; i++) begin
         vecs[i].exp_dout = model_rx(vecs[i].mode, vecs[i].din, vecs[i].miso_byte);
         vecs[i].exp_lat  = 18 * D4;
      end

      // Reset values and quiet period after release.
      #2 rst = 1'b0;
      #1;
      chk("rst_ss", b4.ss, 1'b1);
      chk("rst_sck", b4.sck, 1'b0);
      chk("rst_mosi", b4.mosi, 1'b0);
      chk("rst_busy", b4.busy, 1'b0);
      chk("rst_done", b4.done, 1'b0);
      chk("rst_dout", b4.dout, 8'h00);
      chk("rst_ss2", b2.ss, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_ss", b4.ss, 1'b1);
      chk("idle_busy", b4.busy, 1'b0);
      chk("idle_dout", b4.dout, 8'h00);

      for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

      // start pulse while busy is dropped.
      miso_mode = 2'd0;
      @(negedge clk);
      b4.start = 1'b1; b4.din = 8'h5A;
      @(posedge clk); #1;
      b4.start = 1'b0;
      d0 = done_cnt;
      repeat (19) @(posedge clk);
      @(negedge clk);
      b4.start = 1'b1; b4.din = 8'hFF;
      @(posedge clk); #1;
      b4.start = 1'b0;
      chk("busy_mid", b4.busy, 1'b1);
      wait_done(LIM, cyc);
      chk("busy_start_lat", 20 + cyc, 18 * D4);
      chk("busy_start_dout", b4.dout, 8'h5A);
      repeat (100) @(posedge clk);
      #1;
      chk("busy_start_dones", done_cnt - d0, 1);

      // Reset 30 cycles into a transfer.
      @(negedge clk);
      b4.start = 1'b1; b4.din = 8'h69;
      @(posedge clk); #1;
      b4.start = 1'b0;
      d0 = done_cnt;
      repeat (30) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_ss", b4.ss, 1'b1);
      chk("abort_sck", b4.sck, 1'b0);
      chk("abort_busy", b4.busy, 1'b0);
      chk("abort_mosi", b4.mosi, 1'b0);
      chk("abort_dout", b4.dout, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_idle_ss", b4.ss, 1'b1);
      chk("abort_idle_dout", b4.dout, 8'h00);
      run_xfer(vecs[0]);

      // Back-to-back on the CLK_DIV=2 instance with start held.
      @(negedge clk);
      b2.start = 1'b1; b2.din = 8'h96;
      n_done = 0; last_c = -1; ss_run = 0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (b2.done === 1'b1) begin
            chk("b2b_dout", b2.dout, 8'h96);
            if (last_c >= 0) chk("b2b_period", c - last_c, 18 * D2 + 1);
            last_c = c;
            n_done++;
         end
         if (b2.ss === 1'b1) begin
            ss_run++;
         end else begin
            if (ss_run > 0 && n_done > 0) chk("b2b_ss_gap", ss_run, 1);
            ss_run = 0;
         end
      end
      chk("b2b_count", n_done, (200 - 1 - 18 * D2) / (18 * D2 + 1) + 1);
      @(negedge clk) b2.start = 1'b0;
      cyc = 0;
      while (b2.done !== 1'b1 && cyc < LIM) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b_tail_done", b2.done, 1'b1);
      @(posedge clk); #1;
      chk("b2b_tail_busy", b2.busy, 1'b0);
      chk("b2b_tail_ss", b2.ss, 1'b1);

      chk("sck_low_when_ss_high", sck_ss_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
